// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 byte stream to key-event decoder with a FWFT event FIFO.
// Optional typematic repeat suppression: define PS2_REPEAT_FILTER_EN.
module ps2_scancode_decoder #(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 2_500_000
) (
    input  logic       CLK_50,
    input  logic       nRst,
    input  logic [7:0] iCode,
    input  logic       iCodeReady,
    output logic [7:0] oKey,
    output logic       oExtended,
    output logic       oBreak,
    output logic       oValid,
    input  logic       iAck,
    output logic       oOverflow
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [21:0] TMO_LAST = 22'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_EXT     = 3'd1;
    localparam logic [2:0] S_BRK     = 3'd2;
    localparam logic [2:0] S_EXT_BRK = 3'd3;
    localparam logic [2:0] S_SKIP    = 3'd4;

    logic        rdy_q, stb_q;
    logic [7:0]  byte_q;
    logic [2:0]  state_q, state_d;
    logic [2:0]  skip_q, skip_d;
    logic [21:0] tmo_q, tmo_d;
    logic [AW:0] wr_q, wr_d, rd_q, rd_d;
    logic        ovf_q, ovf_d;
    logic [9:0]  mem_q [FIFO_DEPTH];

    logic        ev_push, ev_ext, ev_brk, push;
    logic        empty, full, pop, do_write;
    logic [9:0]  head;

    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        ev_push = 1'b0;
        ev_ext  = 1'b0;
        ev_brk  = 1'b0;
        tmo_d   = (stb_q || state_q == S_IDLE) ? '0 : tmo_q + 22'd1;
        if (stb_q) begin
            case (state_q)
                S_IDLE: begin
                    case (byte_q)
                        8'hE0: state_d = S_EXT;
                        8'hF0: state_d = S_BRK;
                        8'hE1: begin
                            state_d = S_SKIP;
                            skip_d  = 3'd7;
                        end
                        8'hAA, 8'hFA, 8'hEE, 8'hFC, 8'h00, 8'hFF: ;
                        default: ev_push = 1'b1;
                    endcase
                end
                S_EXT: begin
                    if (byte_q == 8'hF0) begin
                        state_d = S_EXT_BRK;
                    end else begin
                        state_d = S_IDLE;
                        ev_push = (byte_q != 8'h12);
                        ev_ext  = 1'b1;
                    end
                end
                S_BRK: begin
                    state_d = S_IDLE;
                    ev_push = 1'b1;
                    ev_brk  = 1'b1;
                end
                S_EXT_BRK: begin
                    state_d = S_IDLE;
                    ev_push = (byte_q != 8'h12);
                    ev_ext  = 1'b1;
                    ev_brk  = 1'b1;
                end
                S_SKIP: begin
                    skip_d = skip_q - 3'd1;
                    if (skip_q == 3'd1) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE && tmo_q == TMO_LAST) begin
            state_d = S_IDLE;
        end
    end

`ifdef PS2_REPEAT_FILTER_EN
    logic       held_q, held_d;
    logic [8:0] held_key_q, held_key_d;

    always_comb begin
        push       = ev_push;
        held_d     = held_q;
        held_key_d = held_key_q;
        if (ev_push && !ev_brk) begin
            if (held_q && held_key_q == {ev_ext, byte_q}) begin
                push = 1'b0;
            end else begin
                held_d     = 1'b1;
                held_key_d = {ev_ext, byte_q};
            end
        end else if (ev_push && held_q && held_key_q == {ev_ext, byte_q}) begin
            held_d = 1'b0;
        end
    end

    always_ff @(posedge CLK_50) begin
        if (!nRst) begin
            held_q     <= 1'b0;
            held_key_q <= '0;
        end else begin
            held_q     <= held_d;
            held_key_q <= held_key_d;
        end
    end
`else
    always_comb push = ev_push;
`endif

    // Pointers carry one wrap bit so full and empty are distinguishable.
    always_comb begin
        empty    = (wr_q == rd_q);
        full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        pop      = iAck && !empty;
        do_write = push && (!full || pop);
        ovf_d    = push && full && !pop;
        wr_d     = wr_q + {{AW{1'b0}}, do_write};
        rd_d     = rd_q + {{AW{1'b0}}, pop};
        head     = mem_q[rd_q[AW-1:0]];
    end

    always_ff @(posedge CLK_50) begin
        if (!nRst) begin
            rdy_q   <= 1'b0;
            stb_q   <= 1'b0;
            byte_q  <= '0;
            state_q <= S_IDLE;
            skip_q  <= '0;
            tmo_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            ovf_q   <= 1'b0;
        end else begin
            rdy_q   <= iCodeReady;
            stb_q   <= iCodeReady && !rdy_q;
            byte_q  <= iCode;
            state_q <= state_d;
            skip_q  <= skip_d;
            tmo_q   <= tmo_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge CLK_50) begin
        if (nRst && do_write) mem_q[wr_q[AW-1:0]] <= {ev_ext, ev_brk, byte_q};
    end

    assign oValid    = !empty;
    assign oKey      = empty ? '0 : head[7:0];
    assign oExtended = !empty && head[9];
    assign oBreak    = !empty && head[8];
    assign oOverflow = ovf_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Scoreboard bench for ps2_scancode_decoder: expected events queued with stimulus,
// compared as the consumer pops them.
module tb_ps2_scancode_decoder;

    localparam int unsigned TMO = 40;

    logic       clk = 1'b0;
    logic       nRst = 1'b0;
    logic [7:0] iCode = '0;
    logic       iCodeReady = 1'b0;
    logic       iAck = 1'b0;
    logic [7:0] oKey;
    logic       oExtended, oBreak, oValid, oOverflow;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned ovf_cnt  = 0;
    logic [9:0]  exp_q [$];

    ps2_scancode_decoder #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(TMO)) dut (
        .CLK_50(clk), .nRst(nRst), .iCode(iCode), .iCodeReady(iCodeReady),
        .oKey(oKey), .oExtended(oExtended), .oBreak(oBreak), .oValid(oValid),
        .iAck(iAck), .oOverflow(oOverflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (nRst && oOverflow) ovf_cnt++;
        if (nRst && oValid && iAck) begin
            if (exp_q.size() == 0) check("spurious_event", 32'(exp_q.size()), 32'd1);
            else check("event", {22'd0, oExtended, oBreak, oKey}, {22'd0, exp_q.pop_front()});
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        iCode = b;
        iCodeReady = 1'b1;
        repeat (3) @(negedge clk);
        iCodeReady = 1'b0;
        @(negedge clk);
    endtask

    task automatic expect_ev(input logic [7:0] key, input logic ext, input logic brk);
        exp_q.push_back({ext, brk, key});
    endtask

    task automatic drain(input string tag);
        int unsigned n = 0;
        iAck = 1'b1;
        while ((oValid || exp_q.size() != 0) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_empty"}, {31'd0, oValid}, 32'd0);
        check({tag, "_sb"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_valid", {31'd0, oValid}, 32'd0);
        check("rst_key", {24'd0, oKey}, 32'd0);
        check("rst_flags", {30'd0, oExtended, oBreak}, 32'd0);
        check("rst_ovf", {31'd0, oOverflow}, 32'd0);
        nRst = 1'b1;
        iAck = 1'b1;
        repeat (2) @(negedge clk);

        // Make/break with two-cycle latency from the rising edge of iCodeReady.
        expect_ev(8'h2D, 1'b0, 1'b0);
        iCode = 8'h2D; iCodeReady = 1'b1;
        @(negedge clk); check("lat1_early", {31'd0, oValid}, 32'd0); iCodeReady = 1'b0;
        @(negedge clk); check("lat1_on", {31'd0, oValid}, 32'd1);
        repeat (2) @(negedge clk);
        send_byte(8'hF0);
        expect_ev(8'h2D, 1'b0, 1'b1);
        iCode = 8'h2D; iCodeReady = 1'b1;
        @(negedge clk); check("lat2_early", {31'd0, oValid}, 32'd0); iCodeReady = 1'b0;
        @(negedge clk); check("lat2_on", {31'd0, oValid}, 32'd1);
        drain("mkbrk");

        expect_ev(8'h75, 1'b1, 1'b0);
        expect_ev(8'h75, 1'b1, 1'b1);
        send_byte(8'hE0); send_byte(8'h75);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        send_byte(8'hE0); send_byte(8'h12);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h12);
        drain("ext");

        expect_ev(8'h34, 1'b0, 1'b0);
        send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
        send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0); send_byte(8'h77);
        send_byte(8'h34);
        send_byte(8'hAA);
        drain("pause");

        iAck = 1'b0;
        expect_ev(8'h1C, 1'b0, 1'b0);
        expect_ev(8'h1B, 1'b0, 1'b0);
        expect_ev(8'h23, 1'b0, 1'b0);
        expect_ev(8'h2B, 1'b0, 1'b0);
        send_byte(8'h1C); send_byte(8'h1B); send_byte(8'h23); send_byte(8'h2B);
        check("ovf_none_yet", ovf_cnt, 32'd0);
        send_byte(8'h15);
        repeat (2) @(negedge clk);
        check("ovf_once", ovf_cnt, 32'd1);
        check("full_valid", {31'd0, oValid}, 32'd1);
        drain("ovf");

        expect_ev(8'h32, 1'b0, 1'b0);
        send_byte(8'hE0);
        repeat (TMO) @(negedge clk);
        send_byte(8'h32);
        drain("timeout");

        iAck = 1'b0;
        send_byte(8'h1A);
        send_byte(8'hF0);
        nRst = 1'b0;
        send_byte(8'h2D);
        nRst = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_mid_valid", {31'd0, oValid}, 32'd0);
        drain("rstmid");

`ifdef PS2_REPEAT_FILTER_EN
        expect_ev(8'h1C, 1'b0, 1'b0);
        expect_ev(8'h1C, 1'b0, 1'b1);
`else
        expect_ev(8'h1C, 1'b0, 1'b0);
        expect_ev(8'h1C, 1'b0, 1'b0);
        expect_ev(8'h1C, 1'b0, 1'b0);
        expect_ev(8'h1C, 1'b0, 1'b1);
`endif
        send_byte(8'h1C); send_byte(8'h1C); send_byte(8'h1C);
        send_byte(8'hF0); send_byte(8'h1C);
        drain("repeat");
        check("ovf_final", ovf_cnt, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
